// File: rtl/zs_enc_fifo.sv
// Elastic buffer between the zero-skip encoder and the MAC array.
// The producer cannot be stalled, so a push into a full FIFO is dropped and flagged.
module zs_enc_fifo #(
  parameter int M        = 32,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [M*M*DATA_W-1:0]        enc_din,
  input  logic                         enc_vld_i,
  output logic                         enc_afull_o,
  output logic [M*M*DATA_W-1:0]        mac_dout,
  output logic                         mac_vld_o,
  input  logic                         mac_rdy_i,
  output logic [$clog2(DEPTH):0]       level_o,
  output logic                         overflow_o,
  input  logic                         clr_err_i
);

  localparam int W  = M * M * DATA_W;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          push, pop, ovf;

  // Full/empty decisions use only registered level, keeping enc_vld_i off output paths.
  always_comb begin
    pop        = (level_q != '0) && mac_rdy_i;
    push       = enc_vld_i && ((level_q < LW'(DEPTH)) || pop);
    ovf        = enc_vld_i && !push;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (ovf)            overflow_d = 1'b1;
    else if (clr_err_i) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately unreset; the empty mask on mac_dout hides stale data.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= enc_din;
  end

  assign mac_vld_o   = (level_q != '0);
  assign mac_dout    = mac_vld_o ? mem_q[rd_ptr_q] : '0;
  assign level_o     = level_q;
  assign enc_afull_o = (level_q >= LW'(DEPTH - AFULL_TH));
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_zs_enc_fifo.sv
// Directed bench for zs_enc_fifo: single pass, fill/drain, overflow, full push+pop,
// wrap-around under back-pressure, and asynchronous reset mid-operation.
module tb_zs_enc_fifo;

  localparam int M        = 4;
  localparam int DATA_W   = 8;
  localparam int DEPTH    = 4;
  localparam int AFULL_TH = 2;
  localparam int W        = M * M * DATA_W;
  localparam int LW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  enc_din;
  logic          enc_vld_i;
  logic          enc_afull_o;
  logic [W-1:0]  mac_dout;
  logic          mac_vld_o;
  logic          mac_rdy_i;
  logic [LW-1:0] level_o;
  logic          overflow_o;
  logic          clr_err_i;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] pat_a, pat_b, pat_c, pat_d, pat_e, pat_f;
  logic [W-1:0] exp_seq [4];
  logic [W-1:0] sb [$];

  zs_enc_fifo #(.M(M), .DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enc_din     (enc_din),
    .enc_vld_i   (enc_vld_i),
    .enc_afull_o (enc_afull_o),
    .mac_dout    (mac_dout),
    .mac_vld_o   (mac_vld_o),
    .mac_rdy_i   (mac_rdy_i),
    .level_o     (level_o),
    .overflow_o  (overflow_o),
    .clr_err_i   (clr_err_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [W-1:0] d);
    enc_vld_i = 1'b1;
    enc_din   = d;
    step();
    enc_vld_i = 1'b0;
    enc_din   = '0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vld"},   W'(mac_vld_o),   '0);
    chk({tag, "_dout"},  mac_dout,        '0);
    chk({tag, "_level"}, W'(level_o),     '0);
    chk({tag, "_afull"}, W'(enc_afull_o), '0);
    chk({tag, "_ovf"},   W'(overflow_o),  '0);
  endtask

  initial begin
    pat_a = {4{32'hA1A2A3A4}};
    pat_b = {4{32'hB1B2B3B4}};
    pat_c = {4{32'hC1C2C3C4}};
    pat_d = {4{32'hD1D2D3D4}};
    pat_e = {4{32'hE1E2E3E4}};
    pat_f = {4{32'hF1F2F3F4}};
    rst_n = 1'b0; enc_din = '0; enc_vld_i = 1'b0; mac_rdy_i = 1'b0; clr_err_i = 1'b0;
    #2;
    chk_idle("reset");
    step(); step();
    rst_n = 1'b1;
    step();

    // single pass
    mac_rdy_i = 1'b1;
    push_one(pat_a);
    chk("single_vld", W'(mac_vld_o), W'(1));
    chk("single_dout", mac_dout, pat_a);
    step();
    chk("single_vld0", W'(mac_vld_o), '0);
    chk("single_dout0", mac_dout, '0);

    // fill and drain
    mac_rdy_i = 1'b0;
    push_one(pat_a);
    chk("fill_l1", W'(level_o), W'(1));
    chk("fill_af1", W'(enc_afull_o), '0);
    push_one(pat_b);
    chk("fill_l2", W'(level_o), W'(2));
    chk("fill_af2", W'(enc_afull_o), W'(1));
    push_one(pat_c);
    chk("fill_l3", W'(level_o), W'(3));
    push_one(pat_d);
    chk("fill_l4", W'(level_o), W'(4));
    chk("fill_head", mac_dout, pat_a);

    // overflow: E dropped
    push_one(pat_e);
    chk("ovf_level", W'(level_o), W'(4));
    chk("ovf_flag", W'(overflow_o), W'(1));
    chk("ovf_head", mac_dout, pat_a);
    exp_seq[0] = pat_a; exp_seq[1] = pat_b; exp_seq[2] = pat_c; exp_seq[3] = pat_d;
    mac_rdy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_%0d", i), mac_dout, exp_seq[i]);
      step();
    end
    chk("drain_empty", W'(mac_vld_o), '0);
    chk("drain_level", W'(level_o), '0);
    chk("ovf_sticky", W'(overflow_o), W'(1));
    clr_err_i = 1'b1;
    step();
    clr_err_i = 1'b0;
    chk("ovf_clr", W'(overflow_o), '0);

    // full with simultaneous push and pop
    mac_rdy_i = 1'b0;
    push_one(pat_a); push_one(pat_b); push_one(pat_c); push_one(pat_d);
    mac_rdy_i = 1'b1;
    chk("fpp_head", mac_dout, pat_a);
    push_one(pat_e);
    chk("fpp_ovf", W'(overflow_o), '0);
    chk("fpp_level", W'(level_o), W'(4));
    exp_seq[0] = pat_b; exp_seq[1] = pat_c; exp_seq[2] = pat_d; exp_seq[3] = pat_e;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fpp_out_%0d", i), mac_dout, exp_seq[i]);
      step();
    end
    chk("fpp_empty", W'(mac_vld_o), '0);

    // wrap-around with random back-pressure, scoreboard model
    begin
      int sent = 0;
      int recv = 0;
      for (int cyc = 0; cyc < 200 && recv < 10; cyc++) begin
        logic do_pop, do_push;
        logic [W-1:0] d;
        d = {4{8'(sent), 8'(sent * 3 + 1), 8'(~sent), 8'h5A}};
        enc_vld_i = (sent < 10) && ($urandom_range(0, 3) != 0);
        enc_din   = d;
        mac_rdy_i = $urandom_range(0, 1) != 0;
        #1;
        chk("wrap_level", W'(level_o), W'(sb.size()));
        chk("wrap_vld", W'(mac_vld_o), W'(sb.size() != 0));
        if (sb.size() != 0) chk("wrap_dout", mac_dout, sb[0]);
        do_pop  = (sb.size() != 0) && mac_rdy_i;
        do_push = enc_vld_i && ((sb.size() < DEPTH) || do_pop);
        @(posedge clk);
        #1;
        if (do_pop) begin
          void'(sb.pop_front());
          recv++;
        end
        if (do_push) begin
          sb.push_back(d);
          sent++;
        end
      end
      enc_vld_i = 1'b0;
      enc_din   = '0;
      chk("wrap_done", W'(recv), W'(10));
      chk("wrap_ovf", W'(overflow_o), '0);
    end

    // reset mid-operation
    sb.delete();
    mac_rdy_i = 1'b0;
    while (mac_vld_o) begin
      mac_rdy_i = 1'b1;
      step();
    end
    mac_rdy_i = 1'b0;
    push_one(pat_a); push_one(pat_b); push_one(pat_c);
    chk("rst_pre_level", W'(level_o), W'(3));
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("rst_mid");
    rst_n = 1'b1;
    push_one(pat_f);
    chk("rst_post_dout", mac_dout, pat_f);
    chk("rst_post_level", W'(level_o), W'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/zs_enc_fifo.md
ZS_ENC_FIFO -- requirements
Module: zs_enc_fifo

Interface
REQ-001 SHALL have parameter M, default 32; MAC array dimension, where one entry is M*M activations.
REQ-002 SHALL have parameter DATA_W, default 8; activation width in bits.
REQ-003 SHALL have parameter DEPTH, default 4; entry count, a power of 2 and at least 2.
REQ-004 SHALL have parameter AFULL_TH, default 2; almost-full headroom in entries, with 1 <= AFULL_TH < DEPTH.
REQ-005 SHALL have port clk, input, 1 bit; clock; all state changes on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit; reset, asynchronous, active-low.
REQ-007 SHALL have port enc_din, input, M*M*DATA_W bits; zero-skip encoded activation block from the zero-skip wrapper.
REQ-008 SHALL have port enc_vld_i, input, 1 bit; enc_din valid; no ready is returned, because the producer cannot be stalled.
REQ-009 SHALL have port enc_afull_o, output, 1 bit; almost full; drives the producer input stall.
REQ-010 SHALL have port mac_dout, output, M*M*DATA_W bits; head entry to the MAC1K array.
REQ-011 SHALL have port mac_vld_o, output, 1 bit; mac_dout valid.
REQ-012 SHALL have port mac_rdy_i, input, 1 bit; MAC array accepts mac_dout.
REQ-013 SHALL have port level_o, output, $clog2(DEPTH)+1 bits; current occupancy.
REQ-014 SHALL have port overflow_o, output, 1 bit; sticky flag marking a dropped entry.
REQ-015 SHALL have port clr_err_i, input, 1 bit; synchronous clear of overflow_o.

Function
REQ-016 SHALL define push = enc_vld_i && (level < DEPTH || pop).
REQ-017 SHALL define pop = mac_vld_o && mac_rdy_i.
REQ-018 SHALL, on push, write enc_din at the write pointer and advance the write pointer by 1 modulo DEPTH.
REQ-019 SHALL, on pop, advance the read pointer by 1 modulo DEPTH.
REQ-020 SHALL update level by +1 on push only, -1 on pop only, and 0 on both or neither; level never exceeds DEPTH and never goes below 0.
REQ-021 SHALL accept a push and a pop in the same cycle when level == DEPTH, leaving level at DEPTH and dropping nothing.
REQ-022 SHALL have no empty bypass: a push at edge k makes mac_vld_o = 1 after edge k, giving 1-cycle latency.
REQ-023 SHALL drive mac_vld_o = (level != 0), from registered state only.
REQ-024 SHALL drive mac_dout = storage[read pointer] when mac_vld_o = 1, and all zeros when mac_vld_o = 0.
REQ-025 SHALL hold mac_dout and mac_vld_o stable while mac_vld_o && !mac_rdy_i.
REQ-026 SHALL preserve order: entries leave in arrival order with bit-exact data.
REQ-027 SHALL drive enc_afull_o = (level >= DEPTH - AFULL_TH), from registered level.
REQ-028 SHALL treat enc_vld_i with level == DEPTH and no pop as an overflow: enc_din dropped, pointers and storage unchanged, overflow_o set to 1 at the next edge.
REQ-029 SHALL, on clr_err_i = 1, clear overflow_o at the next edge; a new overflow in the same cycle wins and overflow_o stays 1.
REQ-030 SHALL use unsigned pointer and level arithmetic, with pointers $clog2(DEPTH) bits wide, wrapping naturally.
REQ-031 SHALL apply the full and empty checks to registered level only, with no combinational path from enc_vld_i to any output.
REQ-032 SHALL ignore mac_rdy_i while level == 0.

Reset
REQ-033 SHALL, while rst_n = 0, force level_o = 0, both pointers = 0, mac_vld_o = 0, mac_dout = 0, enc_afull_o = 0 and overflow_o = 0.
REQ-034 SHALL leave storage contents unreset; stored data is never visible, because mac_dout is masked to zero when empty.
REQ-035 SHALL, on reset asserted mid-operation, discard all held entries; after release the first push behaves as on an empty FIFO.

Verification
REQ-036 SHALL cover single pass: DEPTH = 4; one push of pattern A with mac_rdy_i = 1 -> mac_vld_o = 1 with mac_dout = A one cycle later; next cycle mac_vld_o = 0 and mac_dout = 0.
REQ-037 SHALL cover fill and drain: 4 pushes A, B, C, D with mac_rdy_i = 0 -> level_o steps 1, 2, 3, 4; enc_afull_o rises when level_o reaches 2; mac_dout holds A; then mac_rdy_i = 1 -> A, B, C, D on consecutive cycles and level_o returns to 0.
REQ-038 SHALL cover overflow: at level_o = 4 with mac_rdy_i = 0, push E -> E dropped, level_o stays 4, overflow_o = 1; drain yields A to D only; pulse clr_err_i -> overflow_o = 0.
REQ-039 SHALL cover full with simultaneous push and pop: at level_o = 4, enc_vld_i = 1 with mac_rdy_i = 1 -> overflow_o stays 0, level_o stays 4, and the output sequence continues with E after D.
REQ-040 SHALL cover wrap-around: 10 push/pop pairs with random back-pressure at about 50% -> output is bit-exact and in order, pointers wrap modulo 4, and level_o never exceeds 4.
REQ-041 SHALL cover reset mid-operation: at level_o = 3, pulse rst_n low asynchronously between edges -> all outputs go to 0 immediately; a post-release push F -> mac_dout = F one cycle later.
